demux8_reg: RTL and testbench
=============================

// Module: demux8_reg
// PURPOSE
//   Registered 1-to-8 bus demultiplexer with per-channel valid/ack handshake.
//   It is the destination end of the CPU internal bus: mux8 selects a source
//   onto the bus, and demux8_reg delivers that word to one of 8 sink registers.
//   Each channel holds its word until the sink acknowledges it, so a busy sink
//   back-pressures the bus without corrupting the other channels.
// PARAMETERS
//   WIDTH  8  data width of the bus word and of each channel register
// PORTS
//   clk        in   1          system clock, all state updates on rising edge
//   rst        in   1          synchronous, active-high reset
//   in_data    in   WIDTH      bus word to deliver
//   in_sel     in   3          destination channel index, 0..7
//   in_valid   in   1          in_data/in_sel valid this cycle
//   in_ready   out  1          demux accepts the word this cycle (combinational)
//   out_data   out  8*WIDTH    channel k data at [k*WIDTH +: WIDTH]
//   out_valid  out  8          channel k holds an unacknowledged word
//   out_ack    in   8          sink k consumes its word this cycle
//   stall_cnt  out  16         back-pressure cycle count (see CONFIGURATION)
// BEHAVIOUR
//   - Reset: out_data all 0, out_valid 8'h00, stall_cnt 0. in_ready follows
//     the rule below, so it is 1 while out_valid is 0. Reset overrides any
//     accept or ack in the same cycle. Words held mid-transfer are discarded.
//   - in_ready = ~out_valid[in_sel] | out_ack[in_sel]. Ready depends only on
//     the selected channel and never on in_valid.
//   - Accept: in_valid & in_ready at an edge. Channel in_sel loads in_data and
//     sets out_valid[in_sel] at that edge. Latency is 1 cycle from accept to
//     out_valid high.
//   - Ack: out_ack[k] & out_valid[k] clears out_valid[k] at the edge, unless
//     the same edge accepts a word into channel k. In that case out_valid[k]
//     stays 1 and out_data slice k takes the new word (back-to-back, no bubble).
//   - out_ack[k] with out_valid[k]=0 is ignored and causes no state change.
//   - While out_valid[k]=1, data slice k is stable until its ack edge.
//   - Channels are independent. Any mix of acks on several channels and one
//     accept can occur in the same cycle.
//   - in_sel and in_data are don't-care while in_valid=0. When in_valid=0, no
//     channel changes except by ack.
//   - The requester holds in_valid, in_sel and in_data stable until accepted.
//     The demux does not check this.
//   - No state machine beyond the per-channel valid bits. The register count
//     is 8*WIDTH + 8 (+16 with stall counter).
// CONFIGURATION
//   DEMUX_STALL_CNT_EN defined:
//     - stall_cnt increments by 1 on every edge with in_valid=1 and in_ready=0.
//     - It saturates at 16'hFFFF and does not wrap.
//     - Only rst clears it.
//   DEMUX_STALL_CNT_EN undefined:
//     - stall_cnt is tied to 16'h0000 and no counter logic is built.
//     - The port list is identical in both builds.
// TESTING
//   1 Reset, then in_sel=3, in_data=8'hA5, in_valid=1 for 1 cycle.
//     -> out_valid=8'h08 next cycle, slice3=8'hA5, other slices 0.
//   2 Ch3 full, no ack, in_sel=3, data=8'h5A held 4 cycles.
//     -> in_ready=0, slice3 stays A5.
//     -> stall_cnt=4 with macro, 0 without.
//   3 Ch3 full, out_ack[3]=1 and accept in_sel=3, data=8'h5A in same cycle.
//     -> in_ready=1, out_valid[3] stays 1, slice3=5A next cycle.
//   4 Ch3 full, in_sel=6, data=8'h3C, out_ack=8'h40 (ch6 empty).
//     -> accepted, out_valid=8'h48, ack on ch6 ignored, slice6=3C.
//   5 out_valid=8'hFF, out_ack=8'hFF, in_valid=0.
//     -> out_valid=8'h00 next cycle, data slices unchanged.
//   6 Macro on, stall forced 65537 cycles.
//     -> stall_cnt=16'hFFFF.
//     -> rst mid-stall: all outputs at reset values next cycle.

Source files
------------

// File: rtl/demux8_reg.sv
// demux8_reg: registered 1-to-8 bus demux with per-channel valid/ack; define DEMUX_STALL_CNT_EN to build the stall counter
module demux8_reg #(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [WIDTH-1:0]   in_data,
   input  logic [2:0]         in_sel,
   input  logic               in_valid,
   output logic               in_ready,
   output logic [8*WIDTH-1:0] out_data,
   output logic [7:0]         out_valid,
   input  logic [7:0]         out_ack,
   output logic [15:0]        stall_cnt
);
   logic [7:0]         r_valid;
   logic [8*WIDTH-1:0] r_data;
   logic [7:0]         w_load;
   assign in_ready  = ~r_valid[in_sel] | out_ack[in_sel];
   assign w_load    = (in_valid & in_ready) ? 8'd1 << in_sel : 8'd0;
   assign out_valid = r_valid;
   assign out_data  = r_data;
   always_ff @(posedge clk)
      r_valid <= rst ? 8'd0 : w_load | (r_valid & ~out_ack);
   for (genvar c = 0; c < 8; c++) begin : g_ch
      always_ff @(posedge clk)
         if (rst) r_data[c*WIDTH +: WIDTH] <= '0;
         else if (w_load[c]) r_data[c*WIDTH +: WIDTH] <= in_data;
   end
`ifdef DEMUX_STALL_CNT_EN
   logic [15:0] r_stall;
   always_ff @(posedge clk)
      if (rst) r_stall <= 16'd0;
      else if (in_valid & ~in_ready & ~&r_stall) r_stall <= r_stall + 16'd1;
   assign stall_cnt = r_stall;
`else
   assign stall_cnt = 16'd0;
`endif
endmodule

// File: tb/tb_demux8_reg.sv
// tb_demux8_reg: directed self-checking bench for demux8_reg
module tb_demux8_reg;
   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  in_data;
   logic [2:0]  in_sel;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] out_data;
   logic [7:0]  out_valid;
   logic [7:0]  out_ack;
   logic [15:0] stall_cnt;
   int checks = 0;
   int errors = 0;
   demux8_reg #(.WIDTH(8)) dut (
      .clk(clk), .rst(rst), .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid),
      .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid), .out_ack(out_ack),
      .stall_cnt(stall_cnt)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   initial begin
      rst = 1'b1; in_data = '0; in_sel = '0; in_valid = 1'b0; out_ack = '0;
      tick(); tick();
      rst = 1'b0;
      #1;
      chk("rst_valid", out_valid, 8'h00);
      chk("rst_data", out_data, 64'h0);
      chk("rst_stall", stall_cnt, 16'h0);
      chk("rst_ready", in_ready, 1'b1);
      in_sel = 3'd3; in_data = 8'hA5; in_valid = 1'b1;
      #1 chk("t1_ready", in_ready, 1'b1);
      tick();
      in_valid = 1'b0;
      chk("t1_valid", out_valid, 8'h08);
      chk("t1_data", out_data, 64'h00000000_A5000000);
      in_data = 8'h5A; in_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1 chk("t2_ready", in_ready, 1'b0);
         tick();
      end
      chk("t2_valid", out_valid, 8'h08);
      chk("t2_data", out_data, 64'h00000000_A5000000);
`ifdef DEMUX_STALL_CNT_EN
      chk("t2_stall", stall_cnt, 16'd4);
`else
      chk("t2_stall", stall_cnt, 16'd0);
`endif
      out_ack = 8'h08;
      #1 chk("t3_ready", in_ready, 1'b1);
      tick();
      in_valid = 1'b0; out_ack = 8'h00;
      chk("t3_valid", out_valid, 8'h08);
      chk("t3_data", out_data, 64'h00000000_5A000000);
      in_sel = 3'd6; in_data = 8'h3C; in_valid = 1'b1; out_ack = 8'h40;
      #1 chk("t4_ready", in_ready, 1'b1);
      tick();
      in_valid = 1'b0; out_ack = 8'h00;
      chk("t4_valid", out_valid, 8'h48);
      chk("t4_data", out_data, 64'h003C0000_5A000000);
      in_sel = 3'd3;
      #1 chk("ready_no_valid", in_ready, 1'b0);
      out_ack = 8'h04;
      tick();
      out_ack = 8'h00;
      chk("ack_empty_valid", out_valid, 8'h48);
      chk("ack_empty_data", out_data, 64'h003C0000_5A000000);
      for (int k = 0; k < 8; k++) begin
         if (k == 3 || k == 6) continue;
         in_sel = 3'(k); in_data = 8'h10 + 8'(k); in_valid = 1'b1;
         tick();
      end
      in_valid = 1'b0; in_sel = 3'd0;
      chk("t5_full_valid", out_valid, 8'hFF);
      chk("t5_full_data", out_data, 64'h173C1514_5A121110);
      chk("t5_full_ready", in_ready, 1'b0);
      out_ack = 8'hFF;
      tick();
      out_ack = 8'h00;
      chk("t5_valid", out_valid, 8'h00);
      chk("t5_data", out_data, 64'h173C1514_5A121110);
      chk("t5_ready", in_ready, 1'b1);
      in_sel = 3'd0; in_data = 8'h77; in_valid = 1'b1;
      tick();
      in_data = 8'h88;
      chk("t6_fill", out_valid, 8'h01);
`ifdef DEMUX_STALL_CNT_EN
      repeat (65537) @(posedge clk);
      #1;
      chk("t6_stall_sat", stall_cnt, 16'hFFFF);
      tick();
      chk("t6_stall_hold", stall_cnt, 16'hFFFF);
`else
      repeat (20) @(posedge clk);
      #1;
      chk("t6_stall_off", stall_cnt, 16'h0);
`endif
      chk("t6_data_stable", out_data[7:0], 8'h77);
      rst = 1'b1;
      tick();
      chk("t6_rst_valid", out_valid, 8'h00);
      chk("t6_rst_data", out_data, 64'h0);
      chk("t6_rst_stall", stall_cnt, 16'h0);
      chk("t6_rst_ready", in_ready, 1'b1);
      rst = 1'b0; in_valid = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
